// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, FSM states, ALU codes
// and the decoded control word passed from mu0_decode to mu0_ctrl.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // EXEC-phase control word; is_mem marks opcodes that wait for MemAck
    typedef struct packed {
        logic       addr_sel;
        logic       pc_sel;
        logic       pc_en;
        logic       acc_en;
        logic [1:0] alu_fn;
        logic       mem_rd;
        logic       mem_wr;
        logic       is_mem;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_word_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational opcode decoder: OpCode/N/Z to the EXEC-phase control word.
// Conditional jumps assert PCSel only together with PCEn (jump taken).
import mu0_pkg::*;

module mu0_decode (
    input  logic [3:0]  OpCode,
    input  logic        N,
    input  logic        Z,
    output ctrl_word_t  cw
);

    always_comb begin
        cw = '0;
        case (OpCode)
            OP_LDA: begin
                cw.addr_sel = 1'b1;
                cw.mem_rd   = 1'b1;
                cw.alu_fn   = ALU_PASS;
                cw.acc_en   = 1'b1;
                cw.is_mem   = 1'b1;
            end
            OP_STA: begin
                cw.addr_sel = 1'b1;
                cw.mem_wr   = 1'b1;
                cw.is_mem   = 1'b1;
            end
            OP_ADD: begin
                cw.addr_sel = 1'b1;
                cw.mem_rd   = 1'b1;
                cw.alu_fn   = ALU_ADD;
                cw.acc_en   = 1'b1;
                cw.is_mem   = 1'b1;
            end
            OP_SUB: begin
                cw.addr_sel = 1'b1;
                cw.mem_rd   = 1'b1;
                cw.alu_fn   = ALU_SUB;
                cw.acc_en   = 1'b1;
                cw.is_mem   = 1'b1;
            end
            OP_JMP: begin
                cw.pc_sel = 1'b1;
                cw.pc_en  = 1'b1;
            end
            OP_JGE: begin
                cw.pc_sel = !N;
                cw.pc_en  = !N;
            end
            OP_JNE: begin
                cw.pc_sel = !Z;
                cw.pc_en  = !Z;
            end
            OP_STP: begin
                cw.is_halt = 1'b1;
            end
            default: begin
                cw.is_halt    = 1'b1;
                cw.is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mu0_ctrl.sv
// MU0 fetch/execute control FSM. Optional retired-instruction counter
// (InstrCount) is built when MU0_PERFCNT_EN is defined.
import mu0_pkg::*;

module mu0_ctrl #(
    parameter int OP_W  = 4
`ifdef MU0_PERFCNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [OP_W-1:0] OpCode,
    input  logic            N,
    input  logic            Z,
    input  logic            MemAck,
    output logic            AddrSel,
    output logic            PCSel,
    output logic            PCEn,
    output logic            IREn,
    output logic            AccEn,
    output logic [1:0]      AluFn,
    output logic            MemRd,
    output logic            MemWr,
    output logic            Halted,
    output logic            Illegal
`ifdef MU0_PERFCNT_EN
    ,
    output logic [CNT_W-1:0] InstrCount
`endif
);

    state_t     state_reg;
    state_t     state_next;
    ctrl_word_t cw;
    logic       illegal_reg;

    mu0_decode u_decode (
        .OpCode (OpCode),
        .N      (N),
        .Z      (Z),
        .cw     (cw)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: if (MemAck) state_next = S_EXEC;
            S_EXEC: begin
                if (cw.is_mem) begin
                    if (MemAck) state_next = S_FETCH;
                end else if (cw.is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Reset overrides every output so an in-flight memory access is dropped
    always_comb begin
        AddrSel = 1'b0;
        PCSel   = 1'b0;
        PCEn    = 1'b0;
        IREn    = 1'b0;
        AccEn   = 1'b0;
        AluFn   = ALU_PASS;
        MemRd   = 1'b0;
        MemWr   = 1'b0;
        Halted  = 1'b0;
        Illegal = 1'b0;
        if (!Reset) begin
            Illegal = illegal_reg;
            case (state_reg)
                S_FETCH: begin
                    MemRd = 1'b1;
                    IREn  = MemAck;
                    PCEn  = MemAck;
                end
                S_EXEC: begin
                    AddrSel = cw.addr_sel;
                    AluFn   = cw.alu_fn;
                    MemRd   = cw.mem_rd;
                    MemWr   = cw.mem_wr;
                    if (cw.is_mem) begin
                        AccEn = cw.acc_en & MemAck;
                    end else begin
                        PCSel = cw.pc_sel;
                        PCEn  = cw.pc_en;
                    end
                end
                S_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == S_EXEC && cw.is_illegal) begin
            illegal_reg <= 1'b1;
        end
    end

`ifdef MU0_PERFCNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Counts completed instructions (STP included, illegal opcodes excluded)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_reg <= '0;
        end else if (state_reg == S_EXEC && state_next != S_EXEC &&
                     !cw.is_illegal && cnt_reg != {CNT_W{1'b1}}) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign InstrCount = Reset ? '0 : cnt_reg;
`endif

endmodule

// File: tb/tb_mu0_ctrl.sv
// Scoreboard bench for mu0_ctrl: each driven cycle queues its hand-computed
// output vector, and a negedge monitor pops and compares.
module tb_mu0_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] OpCode = 4'd0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       MemAck = 1'b1;
    logic       AddrSel, PCSel, PCEn, IREn, AccEn, MemRd, MemWr, Halted, Illegal;
    logic [1:0] AluFn;
`ifdef MU0_PERFCNT_EN
    logic [15:0] InstrCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] vec;
        int          cnt;
        string       name;
    } exp_t;

    exp_t sb[$];

    mu0_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .OpCode     (OpCode),
        .N          (N),
        .Z          (Z),
        .MemAck     (MemAck),
        .AddrSel    (AddrSel),
        .PCSel      (PCSel),
        .PCEn       (PCEn),
        .IREn       (IREn),
        .AccEn      (AccEn),
        .AluFn      (AluFn),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .Halted     (Halted),
        .Illegal    (Illegal)
`ifdef MU0_PERFCNT_EN
        ,
        .InstrCount (InstrCount)
`endif
    );

    always #5 Clk = ~Clk;

    // {AddrSel, PCSel, PCEn, IREn, AccEn, AluFn, MemRd, MemWr, Halted, Illegal}
    function automatic logic [10:0] mk(input logic as, ps, pe, ie, ae,
                                       input logic [1:0] af,
                                       input logic mr, mw, h, il);
        return {as, ps, pe, ie, ae, af, mr, mw, h, il};
    endfunction

    task automatic cyc(input logic rst, input logic [3:0] op, input logic n, z, ack,
                       input logic [10:0] vec, input int cnt, input string name);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset  = rst;
        OpCode = op;
        N      = n;
        Z      = z;
        MemAck = ack;
        e.vec  = vec;
        e.cnt  = cnt;
        e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e   = sb.pop_front();
            act = {AddrSel, PCSel, PCEn, IREn, AccEn, AluFn, MemRd, MemWr, Halted, Illegal};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: outputs got %b expected %b", e.name, act, e.vec);
            end else begin
                $display("ok   %s: outputs %b", e.name, act);
            end
`ifdef MU0_PERFCNT_EN
            checks++;
            if (InstrCount !== 16'(e.cnt)) begin
                errors++;
                $display("FAIL %s: InstrCount got %0d expected %0d", e.name, InstrCount, e.cnt);
            end
`endif
        end
    end

    initial begin
        logic [10:0] z0, fw, fa, hs, hi;
        z0 = '0;
        fw = mk(0,0,0,0,0,2'b00,1,0,0,0);
        fa = mk(0,0,1,1,0,2'b00,1,0,0,0);
        hs = mk(0,0,0,0,0,2'b00,0,0,1,0);
        hi = mk(0,0,0,0,0,2'b00,0,0,1,1);

        for (int i = 0; i < 3; i++) cyc(1, 4'd0, 0, 0, 1, z0, 0, "reset_hold");
        cyc(0, 4'd2, 0, 0, 0, fw, 0, "fetch_wait1");
        cyc(0, 4'd2, 0, 0, 0, fw, 0, "fetch_wait2");
        cyc(0, 4'd2, 0, 0, 1, fa, 0, "fetch_ack_add");
        cyc(0, 4'd2, 0, 0, 1, mk(1,0,0,0,1,2'b01,1,0,0,0), 0, "exec_add");
        cyc(0, 4'd5, 1, 0, 1, fa, 1, "fetch_jge_n1");
        cyc(0, 4'd5, 1, 0, 0, z0, 1, "exec_jge_n1");
        cyc(0, 4'd5, 0, 0, 1, fa, 2, "fetch_jge_n0");
        cyc(0, 4'd5, 0, 0, 0, mk(0,1,1,0,0,2'b00,0,0,0,0), 2, "exec_jge_n0");
        cyc(0, 4'd6, 0, 1, 1, fa, 3, "fetch_jne_z1");
        cyc(0, 4'd6, 0, 1, 0, z0, 3, "exec_jne_z1");
        cyc(0, 4'd4, 0, 0, 1, fa, 4, "fetch_jmp");
        cyc(0, 4'd4, 0, 0, 1, mk(0,1,1,0,0,2'b00,0,0,0,0), 4, "exec_jmp_spurious_ack");
        cyc(0, 4'd1, 0, 0, 1, fa, 5, "fetch_sta");
        cyc(0, 4'd1, 0, 0, 0, mk(1,0,0,0,0,2'b00,0,1,0,0), 5, "exec_sta_wait");
        cyc(0, 4'd1, 0, 0, 1, mk(1,0,0,0,0,2'b00,0,1,0,0), 5, "exec_sta_ack");
        cyc(0, 4'd0, 0, 0, 1, fa, 6, "fetch_lda");
        cyc(0, 4'd0, 0, 0, 1, mk(1,0,0,0,1,2'b00,1,0,0,0), 6, "exec_lda");
        cyc(0, 4'd3, 0, 0, 1, fa, 7, "fetch_sub");
        cyc(0, 4'd3, 0, 0, 0, mk(1,0,0,0,0,2'b10,1,0,0,0), 7, "exec_sub_wait");
        cyc(0, 4'd3, 0, 0, 1, mk(1,0,0,0,1,2'b10,1,0,0,0), 7, "exec_sub_ack");
        cyc(0, 4'd7, 0, 0, 1, fa, 8, "fetch_stp");
        cyc(0, 4'd7, 0, 0, 1, z0, 8, "exec_stp");
        for (int i = 0; i < 10; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            cyc(0, 4'd7, 0, 0, iv[0], hs, 9, "halt_stp");
        end

        cyc(1, 4'd12, 0, 0, 1, z0, 0, "reset_after_stp");
        cyc(0, 4'd12, 0, 0, 1, fa, 0, "fetch_illegal");
        cyc(0, 4'd12, 0, 0, 1, z0, 0, "exec_illegal");
        for (int i = 0; i < 3; i++) cyc(0, 4'd12, 0, 0, 1, hi, 0, "halt_illegal");

        cyc(1, 4'd0, 0, 0, 0, z0, 0, "reset_clear_illegal");
        cyc(0, 4'd0, 0, 0, 0, fw, 0, "fetch_wait_post_reset");
        cyc(0, 4'd0, 0, 0, 1, fa, 0, "fetch_lda2");
        cyc(0, 4'd0, 0, 0, 0, mk(1,0,0,0,0,2'b00,1,0,0,0), 0, "exec_lda_wait");
        cyc(1, 4'd0, 0, 0, 0, z0, 0, "reset_mid_lda");
        cyc(0, 4'd0, 0, 0, 0, fw, 0, "fetch_after_abort");

        repeat (2) @(posedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
